uart_tx: RTL and testbench

Buffered UART transmitter for the UART library. It accepts bytes from the local logic over a valid/ready handshake and stores them in an internal FIFO. It then serialises each byte onto a single line as a start/data/parity/stop frame, LSB first. This is the transmit end of the same line that the UART receiver and its testbench scoreboard consume.

---
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_tx.sv | 129 ++++++++++++
 tb/tb_uart_tx.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - valid/ready byte handshake into the UART transmitter
interface uart_tx_if #(
  parameter int DATASIZE = 8
);
  logic [DATASIZE-1:0] txData;
  logic                txValid;
  logic                txReady;

  modport master (output txData, output txValid, input txReady);
  modport slave  (input txData, input txValid, output txReady);
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered UART transmitter: byte FIFO feeding a start/data/parity/stop serialiser
module uart_tx #(
  parameter int DATASIZE   = 8,
  parameter int CLKSPERBIT = 868,
  parameter int PARITY     = 0,
  parameter int STOPBITS   = 1,
  parameter int FIFODEPTH  = 16,
  parameter int ADDRSIZE   = 4
) (
  input  logic              clk,
  input  logic              rstN,
  uart_tx_if.slave          tx,
  output logic              txOut,
  output logic              busy,
  output logic [ADDRSIZE:0] fifoCount
);
  localparam int TW = $clog2(CLKSPERBIT);
  localparam int BW = (DATASIZE > 1) ? $clog2(DATASIZE) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t              state, state_nxt;
  logic [TW-1:0]       timer;
  logic [BW-1:0]       bitcnt;
  logic [DATASIZE-1:0] shift, shift_nxt, head;
  logic                par_bit, par_nxt;
  logic [DATASIZE-1:0] mem [FIFODEPTH];
  logic [ADDRSIZE-1:0] wrPtr, rdPtr;
  logic                push, pop, bit_end, fifo_nonempty, txout_d;

  assign fifo_nonempty = (fifoCount != '0);
  assign tx.txReady    = (fifoCount != (ADDRSIZE+1)'(FIFODEPTH));
  assign push          = tx.txValid && tx.txReady;
  assign bit_end       = (timer == TW'(CLKSPERBIT - 1));
  assign head          = mem[rdPtr];

  // Next state; pop happens from IDLE or at the very end of the last stop bit
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:  if (fifo_nonempty) begin
               pop       = 1'b1;
               state_nxt = START;
             end
      START: if (bit_end) state_nxt = DATA;
      DATA:  if (bit_end && bitcnt == BW'(DATASIZE - 1))
               state_nxt = (PARITY != 0) ? PAR : STOP;
      PAR:   if (bit_end) state_nxt = STOP;
      STOP:  if (bit_end && bitcnt == BW'(STOPBITS - 1)) begin
               if (fifo_nonempty) begin
                 pop       = 1'b1;
                 state_nxt = START;
               end else begin
                 state_nxt = IDLE;
               end
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shift_nxt = shift;
    par_nxt   = par_bit;
    if (pop) begin
      shift_nxt = head;
      par_nxt   = (PARITY == 1) ? ~^head : ^head;
    end else if (state == DATA && bit_end) begin
      shift_nxt = shift >> 1;
    end
  end

  // Line value for the cycle after the edge, so txOut can be a plain register
  always_comb begin
    txout_d = 1'b1;
    case (state_nxt)
      START:   txout_d = 1'b0;
      DATA:    txout_d = shift_nxt[0];
      PAR:     txout_d = par_nxt;
      default: txout_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= IDLE;
      timer   <= '0;
      bitcnt  <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      txOut   <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      par_bit <= par_nxt;
      txOut   <= txout_d;
      busy    <= (state_nxt != IDLE);
      if (state == IDLE || state_nxt != state || bit_end)
        timer <= '0;
      else
        timer <= timer + 1'b1;
      if (state_nxt != state)
        bitcnt <= '0;
      else if (bit_end)
        bitcnt <= bitcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + 1'b1;
        2'b01:   fifoCount <= fifoCount - 1'b1;
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= tx.txData;
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a queue-based frame model
module tb_uart_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rstN;
  logic       vin;
  logic [7:0] din;
  int         sel;

  logic       txo [4];
  logic       bsy [4];
  logic       rdy [4];
  logic [4:0] cnt [4];
  logic       line_o, busy_o, ready_o;
  logic [4:0] count_o;

  int par_cfg  [4] = '{0, 2, 1, 0};
  int stop_cfg [4] = '{1, 1, 1, 2};

  int n_assert = 0;
  int n_fail   = 0;
  int nbusy;
  logic       last_acc;
  logic [7:0] fifo [$];
  logic       wave [$];
  logic       cap  [$];
  logic [11:0] f;

  always #5 clk = ~clk;

  uart_tx_if #(.DATASIZE(8)) if0 ();
  uart_tx_if #(.DATASIZE(8)) if1 ();
  uart_tx_if #(.DATASIZE(8)) if2 ();
  uart_tx_if #(.DATASIZE(8)) if3 ();

  assign if0.txValid = vin && (sel == 0);
  assign if1.txValid = vin && (sel == 1);
  assign if2.txValid = vin && (sel == 2);
  assign if3.txValid = vin && (sel == 3);
  assign if0.txData = din;
  assign if1.txData = din;
  assign if2.txData = din;
  assign if3.txData = din;
  assign rdy[0] = if0.txReady;
  assign rdy[1] = if1.txReady;
  assign rdy[2] = if2.txReady;
  assign rdy[3] = if3.txReady;

  uart_tx #(.CLKSPERBIT(CPB), .PARITY(0), .STOPBITS(1)) u0 (
    .clk(clk), .rstN(rstN), .tx(if0), .txOut(txo[0]), .busy(bsy[0]), .fifoCount(cnt[0]));
  uart_tx #(.CLKSPERBIT(CPB), .PARITY(2), .STOPBITS(1)) u1 (
    .clk(clk), .rstN(rstN), .tx(if1), .txOut(txo[1]), .busy(bsy[1]), .fifoCount(cnt[1]));
  uart_tx #(.CLKSPERBIT(CPB), .PARITY(1), .STOPBITS(1)) u2 (
    .clk(clk), .rstN(rstN), .tx(if2), .txOut(txo[2]), .busy(bsy[2]), .fifoCount(cnt[2]));
  uart_tx #(.CLKSPERBIT(CPB), .PARITY(0), .STOPBITS(2)) u3 (
    .clk(clk), .rstN(rstN), .tx(if3), .txOut(txo[3]), .busy(bsy[3]), .fifoCount(cnt[3]));

  always_comb begin
    line_o  = txo[sel[1:0]];
    busy_o  = bsy[sel[1:0]];
    ready_o = rdy[sel[1:0]];
    count_o = cnt[sel[1:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole frame as a list of bit values, each repeated for one bit period
  function automatic void add_frame(input logic [7:0] d);
    logic bits [$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (par_cfg[sel] == 2) bits.push_back(($countones(d) % 2) == 1);
    else if (par_cfg[sel] == 1) bits.push_back(($countones(d) % 2) == 0);
    for (int i = 0; i < stop_cfg[sel]; i++) bits.push_back(1'b1);
    foreach (bits[b]) for (int c = 0; c < CPB; c++) wave.push_back(bits[b]);
  endfunction

  task automatic cycle(input logic v, input logic [7:0] d);
    logic acc;
    vin = v;
    din = d;
    chk("txReady", 32'(ready_o), 32'(fifo.size() != 16));
    acc = v && rstN && (fifo.size() != 16);
    @(posedge clk);
    if (!rstN) begin
      fifo.delete();
      wave.delete();
    end else begin
      if (wave.size() != 0) void'(wave.pop_front());
      if (wave.size() == 0 && fifo.size() != 0) add_frame(fifo.pop_front());
      if (acc) fifo.push_back(d);
    end
    last_acc = acc;
    #1;
    vin = 1'b0;
    chk("txOut", 32'(line_o), 32'((wave.size() != 0) ? wave[0] : 1'b1));
    chk("busy", 32'(busy_o), 32'(wave.size() != 0));
    chk("fifoCount", 32'(count_o), fifo.size());
  endtask

  task automatic capture(input int n);
    repeat (n) begin
      cycle(1'b0, 8'h00);
      cap.push_back(line_o);
      if (busy_o === 1'b1) nbusy++;
    end
  endtask

  task automatic chk_frame(input string tag, input logic [11:0] fr, input int nbits, input int off);
    for (int j = 0; j < nbits * CPB; j++) chk(tag, 32'(cap[off + j]), 32'(fr[j / CPB]));
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (wave.size() != 0 || fifo.size() != 0); i++) cycle(1'b0, 8'h00);
    chk("drain_timeout", wave.size() + fifo.size(), 0);
    repeat (2) cycle(1'b0, 8'h00);
  endtask

  initial begin
    rstN = 1'b0;
    vin  = 1'b0;
    din  = 8'h00;
    sel  = 0;
    #12;
    for (int k = 0; k < 4; k++) begin
      chk("rst_txOut", 32'(txo[k]), 1);
      chk("rst_busy", 32'(bsy[k]), 0);
      chk("rst_txReady", 32'(rdy[k]), 1);
      chk("rst_fifoCount", 32'(cnt[k]), 0);
    end
    rstN = 1'b1;

    // Basic frame 0x55, no parity
    sel = 0;
    cycle(1'b1, 8'h55);
    cap.delete(); nbusy = 0;
    capture(41);
    f = 12'({1'b1, 8'h55, 1'b0});
    chk_frame("frame_55", f, 10, 0);
    chk("idle_after_55", 32'(cap[40]), 1);
    chk("busy_cycles_55", nbusy, 40);
    drain();

    // Even parity
    sel = 1;
    cycle(1'b1, 8'h07);
    cap.delete(); nbusy = 0;
    capture(45);
    f = 12'({1'b1, 1'b1, 8'h07, 1'b0});
    chk_frame("frame_even", f, 11, 0);
    chk("busy_cycles_even", nbusy, 44);
    drain();

    // Odd parity
    sel = 2;
    cycle(1'b1, 8'h07);
    cap.delete(); nbusy = 0;
    capture(45);
    f = 12'({1'b1, 1'b0, 8'h07, 1'b0});
    chk_frame("frame_odd", f, 11, 0);
    chk("busy_cycles_odd", nbusy, 44);
    drain();

    // Two stop bits, second byte follows with no gap
    sel = 3;
    cycle(1'b1, 8'hA3);
    cap.delete(); nbusy = 0;
    cycle(1'b1, 8'h3C);
    cap.push_back(line_o);
    capture(48);
    f = 12'({1'b1, 1'b1, 8'hA3, 1'b0});
    chk_frame("frame_stop2", f, 11, 0);
    for (int j = 44; j < 48; j++) chk("stop2_next_start", 32'(cap[j]), 0);
    drain();

    // A few random bytes on the parity configurations
    for (int k = 1; k < 3; k++) begin
      sel = k;
      repeat (3) cycle(1'b1, 8'($urandom));
      drain();
    end

    // Overflow: 18 consecutive pushes, 17 accepted
    sel = 0;
    for (int i = 0; i < 18; i++) cycle(1'b1, 8'($urandom));
    chk("ovf_fifoCount", 32'(count_o), 16);
    chk("ovf_txReady", 32'(ready_o), 0);
    drain();

    // Reset mid-frame during data bit 3 of the first byte
    cycle(1'b1, 8'h11);
    cycle(1'b1, 8'h22);
    cycle(1'b1, 8'h33);
    repeat (17) cycle(1'b0, 8'h00);
    chk("pre_rst_fifoCount", 32'(count_o), 2);
    #2;
    rstN = 1'b0;
    fifo.delete();
    wave.delete();
    #1;
    chk("async_rst_txOut", 32'(line_o), 1);
    chk("async_rst_fifoCount", 32'(count_o), 0);
    chk("async_rst_busy", 32'(busy_o), 0);
    chk("async_rst_txReady", 32'(ready_o), 1);
    repeat (2) cycle(1'b0, 8'h00);
    #2;
    rstN = 1'b1;
    repeat (60) cycle(1'b0, 8'h00);
    chk("post_rst_txOut", 32'(line_o), 1);

    // Wrap-around: 40 incrementing bytes with random valid gaps
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) cycle(1'b0, 8'h00);
      for (int t = 0; t < 200; t++) begin
        cycle(1'b1, 8'(i));
        if (last_acc) break;
      end
      chk("wrap_accept_timeout", 32'(last_acc), 1);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
